// File: rtl/memory_access_cycle.sv
// MEM pipeline stage: runs loads/stores over a req/ack data bus, holds the M-W buffer,
// stalls upstream while a transfer is outstanding and aborts transfers that exceed TIMEOUT.
module memory_access_cycle #(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_INSN = 32'h68000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_M,
    input  logic [31:0] alu_result_M,
    input  logic [31:0] rd2_M,
    input  logic [31:0] instruction_M,
    input  logic        isLd_M,
    input  logic        isSt_M,
    input  logic        isWb_M,
    input  logic        isCall_M,
    input  logic [3:0]  RD_M,
    input  logic [3:0]  ra_M,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        stall_M,
    output logic [31:0] data_M_fwd,
    output logic [31:0] memory_data_out,
    output logic        mem_err,
    output logic [31:0] pc_W,
    output logic [31:0] alu_result_W,
    output logic [31:0] ld_result_W,
    output logic [31:0] instruction_W,
    output logic        isLd_W,
    output logic        isWb_W,
    output logic        isCall_W,
    output logic [3:0]  RD_W,
    output logic [3:0]  ra_W
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] insn;
        logic        isLd;
        logic        isWb;
        logic        isCall;
        logic [3:0]  rd;
        logic [3:0]  ra;
    } wbuf_t;

    localparam logic [7:0] TMO = 8'(TIMEOUT);

    function automatic wbuf_t bubble();
        wbuf_t b;
        b      = '0;
        b.insn = NOP_INSN;
        return b;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    wbuf_t       w_q, w_d;
    wbuf_t       hold_q, hold_d;
    logic [31:0] hold_wdata_q, hold_wdata_d;
    wbuf_t       m_ins;
    logic        is_mem;

    // A simultaneous ld+st is a store, so the effective load flag excludes stores.
    assign m_ins = '{pc: pc_M, alu: alu_result_M, ld: 32'd0, insn: instruction_M,
                     isLd: isLd_M & ~isSt_M, isWb: isWb_M, isCall: isCall_M,
                     rd: RD_M, ra: ra_M};
    assign is_mem = isLd_M | isSt_M;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        hold_d       = hold_q;
        hold_wdata_d = hold_wdata_q;
        w_d          = bubble();
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = 32'd0;
        mem_wdata    = 32'd0;
        stall_M      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_mem) begin
                    mem_req   = 1'b1;
                    mem_we    = isSt_M;
                    mem_addr  = alu_result_M;
                    mem_wdata = rd2_M;
                    if (mem_ack) begin
                        w_d    = m_ins;
                        w_d.ld = m_ins.isLd ? mem_rdata : 32'd0;
                    end else begin
                        stall_M      = 1'b1;
                        hold_d       = m_ins;
                        hold_wdata_d = rd2_M;
                        state_d      = S_WAIT;
                        cnt_d        = 8'd1;
                    end
                end else begin
                    w_d = m_ins;
                end
            end
            S_WAIT: begin
                // Transfer is driven entirely from the hold registers; M is frozen.
                mem_req   = 1'b1;
                mem_we    = ~hold_q.isLd;
                mem_addr  = hold_q.alu;
                mem_wdata = hold_wdata_q;
                if (mem_ack) begin
                    w_d     = hold_q;
                    w_d.ld  = hold_q.isLd ? mem_rdata : 32'd0;
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end else if (cnt_q < TMO) begin
                    stall_M = 1'b1;
                    cnt_d   = sat_inc(cnt_q);
                end else begin
                    err_d   = 1'b1;
                    w_d     = hold_q;
                    w_d.ld  = 32'd0;
                    if (hold_q.isLd) w_d.isWb = 1'b0;
                    state_d = S_IDLE;
                    cnt_d   = 8'd0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            w_q     <= bubble();
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            w_q     <= w_d;
        end
    end

    always_ff @(posedge clk) begin
        hold_q       <= hold_d;
        hold_wdata_q <= hold_wdata_d;
    end

    assign data_M_fwd      = alu_result_M;
    assign memory_data_out = w_q.ld;
    assign mem_err         = err_q;
    assign pc_W            = w_q.pc;
    assign alu_result_W    = w_q.alu;
    assign ld_result_W     = w_q.ld;
    assign instruction_W   = w_q.insn;
    assign isLd_W          = w_q.isLd;
    assign isWb_W          = w_q.isWb;
    assign isCall_W        = w_q.isCall;
    assign RD_W            = w_q.rd;
    assign ra_W            = w_q.ra;

endmodule
